// File: rtl/tlb_pkg.sv
// Shared types for the associative TLB: controller states, entry layout and width helpers.
package tlb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WALK,
    S_VICTIM,
    S_FILL,
    S_RESP,
    S_FLUSH
  } tlb_state_e;

  function automatic int unsigned vpn_w(input int unsigned va_w, input int unsigned off_w);
    return va_w - off_w;
  endfunction

  function automatic int unsigned ppn_w(input int unsigned pa_w, input int unsigned off_w);
    return pa_w - off_w;
  endfunction

  localparam int unsigned DEF_VA_WIDTH     = 14;
  localparam int unsigned DEF_PA_WIDTH     = 10;
  localparam int unsigned DEF_OFFSET_WIDTH = 8;
  localparam int unsigned DEF_ENTRIES      = 4;
  localparam int unsigned DEF_VPN_W        = vpn_w(DEF_VA_WIDTH, DEF_OFFSET_WIDTH);
  localparam int unsigned DEF_PPN_W        = ppn_w(DEF_PA_WIDTH, DEF_OFFSET_WIDTH);

  // Entry layout at the default address widths; tlb_assoc mirrors this layout at its own widths.
  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic                 ref_bit;
    logic [DEF_VPN_W-1:0] vpn;
    logic [DEF_PPN_W-1:0] ppn;
  } tlb_entry_t;

  localparam tlb_entry_t RESET_ENTRY = '0;

endpackage

// File: rtl/tlb_cam_match.sv
// Parallel VPN compare across all TLB entries; at most one valid entry can match.
module tlb_cam_match #(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned VPN_W   = 6,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0] valid_i,
  input  logic [VPN_W-1:0]   tag_i [ENTRIES],
  input  logic [VPN_W-1:0]   key_i,
  output logic               hit_o,
  output logic [ENTRIES-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o
);

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (valid_i[i] && (tag_i[i] == key_i)) begin
        onehot_o[i] = 1'b1;
        idx_o       = IDX_W'(i);
      end
    end
  end

  assign hit_o = |onehot_o;

endmodule

// File: rtl/tlb_assoc.sv
// Fully associative TLB with page-table walk handshake, clock replacement,
// dirty write-back on eviction and a sequential flush.
module tlb_assoc
  import tlb_pkg::*;
#(
  parameter int unsigned VA_WIDTH     = DEF_VA_WIDTH,
  parameter int unsigned PA_WIDTH     = DEF_PA_WIDTH,
  parameter int unsigned OFFSET_WIDTH = DEF_OFFSET_WIDTH,
  parameter int unsigned ENTRIES      = DEF_ENTRIES
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [VA_WIDTH-1:0]              req_vaddr,
  input  logic                             req_write,
  input  logic                             flush,
  output logic                             resp_valid,
  output logic [PA_WIDTH-1:0]              resp_paddr,
  output logic                             resp_hit,
  output logic                             resp_fault,
  output logic                             pt_req_valid,
  output logic [VA_WIDTH-OFFSET_WIDTH-1:0] pt_req_vpn,
  input  logic                             pt_resp_valid,
  input  logic [PA_WIDTH-OFFSET_WIDTH-1:0] pt_resp_ppn,
  input  logic                             pt_resp_fault,
  output logic                             wb_valid,
  output logic [VA_WIDTH-OFFSET_WIDTH-1:0] wb_vpn,
  output logic [PA_WIDTH-OFFSET_WIDTH-1:0] wb_ppn,
  output logic                             busy
);

  localparam int unsigned VPN_W = vpn_w(VA_WIDTH, OFFSET_WIDTH);
  localparam int unsigned PPN_W = ppn_w(PA_WIDTH, OFFSET_WIDTH);
  localparam int unsigned IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic             ref_bit;
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
  } entry_t;

  tlb_state_e          state_q, state_d;
  entry_t              entries_q [ENTRIES];
  entry_t              entries_d [ENTRIES];
  logic [IDX_W-1:0]    hand_q, hand_d;
  logic [IDX_W-1:0]    victim_q, victim_d;
  logic [IDX_W-1:0]    fidx_q, fidx_d;
  logic [VA_WIDTH-1:0] vaddr_q, vaddr_d;
  logic                write_q, write_d;
  logic [PPN_W-1:0]    ppn_q, ppn_d;
  logic                hit_q, hit_d;
  logic                fault_q, fault_d;

  logic [ENTRIES-1:0]  valid_vec;
  logic [VPN_W-1:0]    tag_vec [ENTRIES];
  logic                cam_hit;
  logic [ENTRIES-1:0]  cam_onehot;
  logic [IDX_W-1:0]    cam_idx;
  logic                inv_found;
  logic [IDX_W-1:0]    inv_idx;
  entry_t              wb_entry;

  always_comb begin
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      valid_vec[i] = entries_q[i].valid;
      tag_vec[i]   = entries_q[i].vpn;
    end
  end

  tlb_cam_match #(
    .ENTRIES (ENTRIES),
    .VPN_W   (VPN_W),
    .IDX_W   (IDX_W)
  ) u_cam (
    .valid_i  (valid_vec),
    .tag_i    (tag_vec),
    .key_i    (req_vaddr[VA_WIDTH-1:OFFSET_WIDTH]),
    .hit_o    (cam_hit),
    .onehot_o (cam_onehot),
    .idx_o    (cam_idx)
  );

  // Downward scan so the lowest invalid index is the one that sticks.
  always_comb begin
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int unsigned i = ENTRIES; i > 0; i--) begin
      if (!entries_q[i-1].valid) begin
        inv_found = 1'b1;
        inv_idx   = IDX_W'(i - 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      for (int unsigned i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
      hand_q   <= '0;
      victim_q <= '0;
      fidx_q   <= '0;
      vaddr_q  <= '0;
      write_q  <= 1'b0;
      ppn_q    <= '0;
      hit_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      entries_q <= entries_d;
      hand_q    <= hand_d;
      victim_q  <= victim_d;
      fidx_q    <= fidx_d;
      vaddr_q   <= vaddr_d;
      write_q   <= write_d;
      ppn_q     <= ppn_d;
      hit_q     <= hit_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    entries_d = entries_q;
    hand_d    = hand_q;
    victim_d  = victim_q;
    fidx_d    = fidx_q;
    vaddr_d   = vaddr_q;
    write_d   = write_q;
    ppn_d     = ppn_q;
    hit_d     = hit_q;
    fault_d   = fault_q;
    unique case (state_q)
      S_IDLE: begin
        if (flush) begin
          fidx_d  = '0;
          state_d = S_FLUSH;
        end else if (req_valid) begin
          vaddr_d = req_vaddr;
          write_d = req_write;
          fault_d = 1'b0;
          hit_d   = cam_hit;
          if (cam_hit) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
              if (cam_onehot[i]) begin
                entries_d[i].ref_bit = 1'b1;
                if (req_write) entries_d[i].dirty = 1'b1;
              end
            end
            ppn_d   = entries_q[cam_idx].ppn;
            state_d = S_RESP;
          end else begin
            state_d = S_WALK;
          end
        end
      end
      S_WALK: begin
        if (pt_resp_valid) begin
          if (pt_resp_fault) begin
            fault_d = 1'b1;
            state_d = S_RESP;
          end else begin
            ppn_d   = pt_resp_ppn;
            state_d = S_VICTIM;
          end
        end
      end
      S_VICTIM: begin
        if (inv_found) begin
          victim_d = inv_idx;
          state_d  = S_FILL;
        end else if (entries_q[hand_q].ref_bit) begin
          entries_d[hand_q].ref_bit = 1'b0;
          hand_d = hand_q + 1'b1;
        end else begin
          victim_d = hand_q;
          hand_d   = hand_q + 1'b1;
          state_d  = S_FILL;
        end
      end
      S_FILL: begin
        entries_d[victim_q] = '{valid:   1'b1,
                                dirty:   write_q,
                                ref_bit: 1'b1,
                                vpn:     vaddr_q[VA_WIDTH-1:OFFSET_WIDTH],
                                ppn:     ppn_q};
        state_d = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      S_FLUSH: begin
        entries_d[fidx_q] = '0;
        hand_d = '0;
        if (fidx_q == IDX_W'(ENTRIES - 1)) state_d = S_IDLE;
        else fidx_d = fidx_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (state_q == S_IDLE);
    busy         = (state_q != S_IDLE);
    pt_req_valid = (state_q == S_WALK);
    pt_req_vpn   = pt_req_valid ? vaddr_q[VA_WIDTH-1:OFFSET_WIDTH] : '0;
    resp_valid   = (state_q == S_RESP);
    resp_hit     = resp_valid && hit_q && !fault_q;
    resp_fault   = resp_valid && fault_q;
    resp_paddr   = (resp_valid && !fault_q) ? {ppn_q, vaddr_q[OFFSET_WIDTH-1:0]} : '0;
    wb_entry     = (state_q == S_FLUSH) ? entries_q[fidx_q] : entries_q[victim_q];
    wb_valid     = ((state_q == S_FILL) || (state_q == S_FLUSH)) && wb_entry.valid && wb_entry.dirty;
    wb_vpn       = wb_valid ? wb_entry.vpn : '0;
    wb_ppn       = wb_valid ? wb_entry.ppn : '0;
  end

endmodule
